ascon_perm_sched: RTL and testbench

- Sequencer for the ASCON-128 initialization phase.
- On a start handshake it captures key and nonce and builds the initial 320-bit state IV||K||N.
- It then steps an external one-round-per-cycle permutation datapath for ROUNDS_A rounds, applies the final key XOR, and publishes the result with update/finished pulses and a sticky interrupt.
- It sits between the ASCON register block (start, key, nonce, result) and the round datapath.

---
 rtl/ascon_pkg.sv | 32 +++
 rtl/ascon_round.sv | 40 ++++
 rtl/ascon_perm_sched.sv | 131 +++++++++++++
 tb/tb_ascon_perm_sched.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared types, constants and helpers for the ASCON-128 initialization sequencer
// and its single-round permutation datapath.
package ascon_pkg;

  localparam int unsigned XW         = 64;
  localparam int unsigned NW         = 5;
  localparam int unsigned KW         = 128;
  localparam int unsigned RCW        = 8;
  localparam int unsigned CNTW       = 4;
  localparam int unsigned MAX_ROUNDS = 12;

  // Permutation state; word 0 is x0.
  typedef logic [NW-1:0][XW-1:0] state_t;

  localparam logic [XW-1:0] ASCON128_IV = 64'h80400c0600000000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FINAL,
    S_DONE
  } sched_state_e;

  function automatic logic [RCW-1:0] ascon_rc(input logic [3:0] r);
    return {4'(4'hF - r), r};
  endfunction

  function automatic logic [XW-1:0] rotr(input logic [XW-1:0] x, input int unsigned n);
    return (x >> n) | (x << (XW - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// Combinational single ASCON round: constant addition, bitsliced 5-bit S-box
// layer and per-word linear diffusion.
module ascon_round
  import ascon_pkg::*;
(
  input  state_t         i_state,
  input  logic [RCW-1:0] i_rc,
  output state_t         o_state
);

  logic [XW-1:0] w_a0, w_a1, w_a2, w_a3, w_a4;
  logic [XW-1:0] w_b0, w_b1, w_b2, w_b3, w_b4;
  logic [XW-1:0] w_s0, w_s1, w_s2, w_s3, w_s4;

  // Constant lands in x2, folded into the S-box input mixing.
  assign w_a0 = i_state[0] ^ i_state[4];
  assign w_a1 = i_state[1];
  assign w_a2 = i_state[2] ^ XW'(i_rc) ^ i_state[1];
  assign w_a3 = i_state[3];
  assign w_a4 = i_state[4] ^ i_state[3];

  assign w_b0 = w_a0 ^ (~w_a1 & w_a2);
  assign w_b1 = w_a1 ^ (~w_a2 & w_a3);
  assign w_b2 = w_a2 ^ (~w_a3 & w_a4);
  assign w_b3 = w_a3 ^ (~w_a4 & w_a0);
  assign w_b4 = w_a4 ^ (~w_a0 & w_a1);

  assign w_s0 = w_b0 ^ w_b4;
  assign w_s1 = w_b1 ^ w_b0;
  assign w_s2 = ~w_b2;
  assign w_s3 = w_b3 ^ w_b2;
  assign w_s4 = w_b4;

  assign o_state[0] = w_s0 ^ rotr(w_s0, 19) ^ rotr(w_s0, 28);
  assign o_state[1] = w_s1 ^ rotr(w_s1, 61) ^ rotr(w_s1, 39);
  assign o_state[2] = w_s2 ^ rotr(w_s2, 1)  ^ rotr(w_s2, 6);
  assign o_state[3] = w_s3 ^ rotr(w_s3, 10) ^ rotr(w_s3, 17);
  assign o_state[4] = w_s4 ^ rotr(w_s4, 7)  ^ rotr(w_s4, 41);

endmodule

// File: rtl/ascon_perm_sched.sv
// ASCON-128 initialization sequencer: loads IV||K||N, steps an external round
// datapath ROUNDS_A times, applies the final key XOR and publishes the result.
module ascon_perm_sched
  import ascon_pkg::*;
#(
  parameter int unsigned     ROUNDS_A = 12,
  parameter logic [XW-1:0]   IV       = ASCON128_IV
)(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic           abort_i,
  input  logic [KW-1:0]  key_i,
  input  logic [KW-1:0]  nonce_i,
  output logic           busy_o,
  output state_t         round_state_o,
  output logic [RCW-1:0] round_const_o,
  input  state_t         round_state_i,
  output state_t         state_o,
  output logic           update_state_o,
  output logic           finished_o,
  output logic           intr_o,
  input  logic           intr_clr_i
);

  if (ROUNDS_A < 1 || ROUNDS_A > MAX_ROUNDS) begin : g_bad_rounds
    $error("ascon_perm_sched: ROUNDS_A must be within 1..12");
  end

  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(ROUNDS_A - 1);
  localparam logic [CNTW-1:0] R_BASE   = CNTW'(MAX_ROUNDS - ROUNDS_A);

  sched_state_e    r_fsm;
  state_t          r_state;
  logic [KW-1:0]   r_key;
  logic [CNTW-1:0] r_cnt;
  logic            r_busy;
  logic [RCW-1:0]  r_rc;
  logic            r_update;
  logic            r_finished;
  logic            r_intr;

  // Sequencer; the round constant is registered one step ahead of the counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fsm      <= S_IDLE;
      r_state    <= '0;
      r_key      <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_rc       <= '0;
      r_update   <= 1'b0;
      r_finished <= 1'b0;
      r_intr     <= 1'b0;
    end else begin
      r_update   <= 1'b0;
      r_finished <= 1'b0;
      if (intr_clr_i) r_intr <= 1'b0;

      case (r_fsm)
        S_IDLE: begin
          if (start_i) begin
            r_state[0] <= IV;
            r_state[1] <= key_i[KW-1:XW];
            r_state[2] <= key_i[XW-1:0];
            r_state[3] <= nonce_i[KW-1:XW];
            r_state[4] <= nonce_i[XW-1:0];
            r_key      <= key_i;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_rc       <= ascon_rc(R_BASE);
            r_fsm      <= S_ROUND;
          end
        end

        S_ROUND: begin
          if (abort_i) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_rc   <= '0;
            r_fsm  <= S_IDLE;
          end else begin
            r_state <= round_state_i;
            r_cnt   <= CNTW'(r_cnt + 4'd1);
            if (r_cnt == LAST_CNT) begin
              r_rc  <= '0;
              r_fsm <= S_FINAL;
            end else begin
              r_rc  <= ascon_rc(CNTW'(R_BASE + r_cnt + 4'd1));
            end
          end
        end

        S_FINAL: begin
          if (abort_i) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_fsm  <= S_IDLE;
          end else begin
            r_state[3] <= r_state[3] ^ r_key[KW-1:XW];
            r_state[4] <= r_state[4] ^ r_key[XW-1:0];
            r_update   <= 1'b1;
            r_finished <= 1'b1;
            r_intr     <= 1'b1;
            r_fsm      <= S_DONE;
          end
        end

        S_DONE: begin
          r_busy <= 1'b0;
          r_fsm  <= S_IDLE;
        end

        default: begin
          r_busy <= 1'b0;
          r_rc   <= '0;
          r_fsm  <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o         = r_busy;
  assign round_state_o  = r_state;
  assign state_o        = r_state;
  assign round_const_o  = r_rc;
  assign update_state_o = r_update;
  assign finished_o     = r_finished;
  assign intr_o         = r_intr;

endmodule

// File: tb/tb_ascon_perm_sched.sv
// Directed bench for ascon_perm_sched: identity and real-round datapaths,
// a ROUNDS_A=6 instance, abort, reset and interrupt corner cases.
`timescale 1ns/1ps
module tb_ascon_perm_sched;
  import ascon_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, start = 1'b0, abort = 1'b0, intr_clr = 1'b0, use_real = 1'b0;
  logic [127:0]  key = '0, nonce = '0;
  logic          busy, upd, fin, intr;
  logic [7:0]    rc;
  state_t        rso, rsi, st, rt_out;

  logic          start6 = 1'b0, abort6 = 1'b0, clr6 = 1'b0;
  logic          busy6, upd6, fin6, intr6;
  logic [7:0]    rc6;
  state_t        rso6, st6;

  ascon_round u_round (.i_state(rso), .i_rc(rc), .o_state(rt_out));
  assign rsi = use_real ? rt_out : rso;

  ascon_perm_sched #(.ROUNDS_A(12)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .key_i(key), .nonce_i(nonce), .busy_o(busy), .round_state_o(rso),
    .round_const_o(rc), .round_state_i(rsi), .state_o(st),
    .update_state_o(upd), .finished_o(fin), .intr_o(intr), .intr_clr_i(intr_clr));

  ascon_perm_sched #(.ROUNDS_A(6)) dut6 (
    .clk_i(clk), .rst_i(rst), .start_i(start6), .abort_i(abort6),
    .key_i(key), .nonce_i(nonce), .busy_o(busy6), .round_state_o(rso6),
    .round_const_o(rc6), .round_state_i(rso6), .state_o(st6),
    .update_state_o(upd6), .finished_o(fin6), .intr_o(intr6), .intr_clr_i(clr6));

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] N1 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [7:0] RC12 [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                                       8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference round using the S-box lookup table per bit column.
  function automatic state_t model_round(input state_t s, input int r);
    state_t a, b, y;
    logic [4:0] v, o;
    logic [7:0] c;
    c = 8'(((15 - r) << 4) | r);
    a = s;
    a[2] = a[2] ^ {56'd0, c};
    b = '0;
    for (int j = 0; j < 64; j++) begin
      v = {a[0][j], a[1][j], a[2][j], a[3][j], a[4][j]};
      o = SBOX[v];
      b[0][j] = o[4]; b[1][j] = o[3]; b[2][j] = o[2]; b[3][j] = o[1]; b[4][j] = o[0];
    end
    y[0] = b[0] ^ ror64(b[0], 19) ^ ror64(b[0], 28);
    y[1] = b[1] ^ ror64(b[1], 61) ^ ror64(b[1], 39);
    y[2] = b[2] ^ ror64(b[2], 1)  ^ ror64(b[2], 6);
    y[3] = b[3] ^ ror64(b[3], 10) ^ ror64(b[3], 17);
    y[4] = b[4] ^ ror64(b[4], 7)  ^ ror64(b[4], 41);
    return y;
  endfunction

  function automatic state_t model_init(input logic [127:0] k, input logic [127:0] n, input int nr);
    state_t s;
    s[0] = 64'h80400c0600000000;
    s[1] = k[127:64]; s[2] = k[63:0]; s[3] = n[127:64]; s[4] = n[63:0];
    for (int r = 0; r < nr; r++) s = model_round(s, r);
    return s;
  endfunction

  state_t exp_id, gold, partial, cap;
  int     nfin, nupd;

  initial begin
    exp_id[0] = 64'h80400c0600000000;
    exp_id[1] = 64'h0001020304050607;
    exp_id[2] = 64'h08090a0b0c0d0e0f;
    exp_id[3] = 64'h0f0f0f0f0f0f0f0f;
    exp_id[4] = 64'h0f0f0f0f0f0f0f0f;
    gold = model_init(128'd0, 128'd0, 12);
    partial = model_init(128'd0, 128'd0, 4);

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", busy, 0); check("rst_rc", rc, 0); check("rst_state", st, 0);
    check("rst_upd", upd, 0);   check("rst_fin", fin, 0); check("rst_intr", intr, 0);

    // Identity datapath, ROUNDS_A=12: constant trace and 13-edge latency
    key = K1; nonce = N1; start = 1'b1;
    tick(); start = 1'b0;
    check("id_busy", busy, 1);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("rc12_%0d", i), rc, RC12[i]);
      check($sformatf("id_nofin_%0d", i), fin, 0);
      tick();
    end
    check("rc12_final_zero", rc, 0);
    check("id_final_nofin", fin, 0);
    tick();
    check("id_fin", fin, 1); check("id_upd", upd, 1); check("id_intr", intr, 1);
    check("id_state", st, exp_id);
    tick();
    check("id_idle_busy", busy, 0); check("id_fin_pulse", fin, 0); check("id_intr_sticky", intr, 1);
    intr_clr = 1'b1; tick(); intr_clr = 1'b0;
    check("id_intr_clr", intr, 0);

    // ROUNDS_A=6 instance
    start6 = 1'b1; tick(); start6 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rc6_%0d", i), rc6, RC12[6 + i]);
      tick();
    end
    check("rc6_final_zero", rc6, 0); check("r6_nofin", fin6, 0);
    tick();
    check("r6_fin", fin6, 1); check("r6_state", st6, exp_id);

    // Real round datapath, K=0, N=0
    use_real = 1'b1; key = '0; nonce = '0;
    start = 1'b1; tick(); start = 1'b0;
    nfin = 0; nupd = 0; cap = '0;
    for (int i = 0; i < 20; i++) begin
      if (fin) cap = st;
      nfin += int'(fin); nupd += int'(upd);
      tick();
    end
    check("real_upd_count", 320'(nupd), 1); check("real_fin_count", 320'(nfin), 1);
    check("real_state", cap, gold); check("real_intr_held", intr, 1);
    intr_clr = 1'b1; tick(); intr_clr = 1'b0;
    check("real_intr_clr", intr, 0);

    // Abort in the 5th ROUND cycle, then immediate restart
    start = 1'b1; tick(); start = 1'b0;
    nfin = 0;
    for (int i = 0; i < 4; i++) begin nfin += int'(fin); tick(); end
    check("abort_rc_cnt4", rc, 8'hb4);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_busy", busy, 0); check("abort_rc", rc, 0); check("abort_fin", fin, 0);
    check("abort_intr", intr, 0); check("abort_partial", st, partial);
    check("abort_prefin", 320'(nfin), 0);
    start = 1'b1; tick(); start = 1'b0;
    check("restart_busy", busy, 1);
    nfin = 0; cap = '0;
    for (int i = 0; i < 14; i++) begin
      if (fin) cap = st;
      nfin += int'(fin);
      tick();
    end
    check("restart_fin_count", 320'(nfin), 1); check("restart_state", cap, gold);
    intr_clr = 1'b1; tick(); intr_clr = 1'b0;

    // start_i held high while busy: one completion only
    use_real = 1'b0; key = K1; nonce = N1;
    start = 1'b1; tick();
    nfin = 0;
    for (int i = 0; i < 13; i++) begin tick(); nfin += int'(fin); end
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin tick(); nfin += int'(fin); end
    check("held_start_fin_count", 320'(nfin), 1); check("held_start_idle", busy, 0);
    check("held_start_intr", intr, 1);

    // Reset in 3rd ROUND cycle
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_busy", busy, 0); check("mid_rst_rc", rc, 0); check("mid_rst_state", st, 0);
    check("mid_rst_rso", rso, 0);   check("mid_rst_fin", fin, 0); check("mid_rst_upd", upd, 0);
    check("mid_rst_intr", intr, 0);

    // intr_clr on the DONE-entry edge: set wins
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    intr_clr = 1'b1; tick();
    check("setclr_fin", fin, 1); check("setclr_intr", intr, 1);
    tick(); intr_clr = 1'b0;
    check("setclr_after", intr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
